// File: rtl/contador_axil_arbiter.sv
// contador_axil_arbiter: two-requester round-robin AXI4-Lite master front-end for the counter IP.
// Define CONTADOR_POLL_EN to add the periodic auto-poll read of C_POLL_ADDR into poll_value.

module contador_axil_arbiter #(
    parameter int unsigned             C_ADDR_WIDTH  = 4,
    parameter int unsigned             C_DATA_WIDTH  = 32,
    parameter int unsigned             C_POLL_PERIOD = 1000,
    parameter logic [C_ADDR_WIDTH-1:0] C_POLL_ADDR   = '0
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_we,
    input  logic [2*C_ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*C_DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                  resp_valid,
    output logic [C_DATA_WIDTH-1:0]     resp_rdata,
    output logic                        resp_err,
    output logic [C_DATA_WIDTH-1:0]     poll_value,
    output logic [C_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                  M_AXI_AWPROT,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                  M_AXI_ARPROT,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q;
    logic                    owner_q;
    logic                    is_poll_q;
    logic                    aw_done_q;
    logic                    w_done_q;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [C_DATA_WIDTH-1:0] wdata_q;

    logic                    grant_any;
    logic                    grant_id;
    logic                    poll_pending;
    logic [C_ADDR_WIDTH-1:0] sel_addr;
    logic [C_DATA_WIDTH-1:0] sel_wdata;

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_AWPROT = '0;
    assign M_AXI_ARPROT = '0;
    assign M_AXI_WSTRB  = '1;

    // Round-robin: the requester that did not win last time has priority.
    always_comb begin
        grant_any = |req_valid;
        grant_id  = last_grant_q;
        if (req_valid[~last_grant_q]) grant_id = ~last_grant_q;
        sel_addr  = grant_id ? req_addr[2*C_ADDR_WIDTH-1:C_ADDR_WIDTH] : req_addr[C_ADDR_WIDTH-1:0];
        sel_wdata = grant_id ? req_wdata[2*C_DATA_WIDTH-1:C_DATA_WIDTH] : req_wdata[C_DATA_WIDTH-1:0];
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = '0;
        resp_valid    = '0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready[grant_id] = 1'b1;
                    state_d = req_we[grant_id] ? WR : RD_ADDR;
                end else if (poll_pending) begin
                    state_d = RD_ADDR;
                end
            end
            WR: begin
                M_AXI_AWVALID = ~aw_done_q;
                M_AXI_WVALID  = ~w_done_q;
                if ((aw_done_q || M_AXI_AWREADY) && (w_done_q || M_AXI_WREADY))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) state_d = DONE;
            end
            RD_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) state_d = DONE;
            end
            DONE: begin
                if (!is_poll_q) resp_valid[owner_q] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            is_poll_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (grant_any) begin
                        owner_q      <= grant_id;
                        last_grant_q <= grant_id;
                        is_poll_q    <= 1'b0;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                    end else if (poll_pending) begin
                        is_poll_q <= 1'b1;
                        addr_q    <= C_POLL_ADDR;
                    end
                end
                WR: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_q <= 1'b1;
                    if (M_AXI_WVALID && M_AXI_WREADY)   w_done_q  <= 1'b1;
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        resp_err   <= (M_AXI_BRESP != 2'b00);
                        resp_rdata <= '0;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID && !is_poll_q) begin
                        resp_err   <= (M_AXI_RRESP != 2'b00);
                        resp_rdata <= M_AXI_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CONTADOR_POLL_EN
    logic [31:0] poll_cnt_q;
    logic        poll_pending_q;
    logic        poll_wrap;
    logic        poll_done;

    assign poll_wrap    = (poll_cnt_q == 32'(C_POLL_PERIOD - 1));
    assign poll_done    = (state_q == RD_DATA) && is_poll_q && M_AXI_RVALID;
    assign poll_pending = poll_pending_q;

    // Pending is sticky, so a wrap while already pending never queues a second poll.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            poll_cnt_q     <= '0;
            poll_pending_q <= 1'b0;
            poll_value     <= '0;
        end else begin
            poll_cnt_q <= poll_wrap ? '0 : poll_cnt_q + 32'd1;
            if (poll_done) begin
                poll_value     <= M_AXI_RDATA;
                poll_pending_q <= 1'b0;
            end else if (poll_wrap) begin
                poll_pending_q <= 1'b1;
            end
        end
    end
`else
    assign poll_pending = 1'b0;
    assign poll_value   = '0;
`endif

endmodule
